// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and types.
// Used by the timing generator and the pixel renderer.
package vga_timing_pkg;

  localparam int CW = 10;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam int H_TOTAL =
    H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOTAL =
    V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  typedef logic [CW-1:0] pos_t;
  typedef logic [7:0]    frame_t;

  function automatic int axis_total(
    input int act,
    input int fp,
    input int sync,
    input int bp
  );
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-advance enable in, raster position and
// sync/blanking strobes out.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic   pix_ce;
  pos_t   hpos;
  pos_t   vpos;
  logic   hsync;
  logic   vsync;
  logic   display_on;
  logic   vblank_start;
  frame_t frame_count;

  modport master (
    input  pix_ce,
    output hpos,
    output vpos,
    output hsync,
    output vsync,
    output display_on,
    output vblank_start,
    output frame_count
  );

  modport slave (
    output pix_ce,
    input  hpos,
    input  vpos,
    input  hsync,
    input  vsync,
    input  display_on,
    input  vblank_start,
    input  frame_count
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus next-value
// decode of the sync window and the visible region.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL   = H_TOTAL,
  parameter int ACTIVE  = H_ACTIVE_D,
  parameter int SYNC_LO = H_ACTIVE_D + H_FP_D,
  parameter int SYNC_HI = H_ACTIVE_D + H_FP_D + H_SYNC_D
) (
  input  logic clk,
  input  logic rst,
  input  logic adv,
  output pos_t cnt_q,
  output pos_t cnt_d,
  output logic last,
  output logic win_d,
  output logic act_d
);

  localparam pos_t LAST_V = pos_t'(TOTAL - 1);
  localparam pos_t ACT_V  = pos_t'(ACTIVE);
  localparam pos_t LO_V   = pos_t'(SYNC_LO);
  localparam pos_t HI_V   = pos_t'(SYNC_HI);

  // Decodes look at the next value so the
  // registered outputs line up with cnt_q.
  always_comb begin
    last  = (cnt_q == LAST_V);
    cnt_d = cnt_q;
    if (adv) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
    win_d = (cnt_d >= LO_V) && (cnt_d < HI_V);
    act_d = (cnt_d < ACT_V);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: position counters, registered
// syncs, display enable, vblank strobe, frame count.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int SYNC_POL = 0
) (
  input  logic clk,
  input  logic sys_rst,
  vga_timing_gen_if.master vif
);

  localparam int H_TOT =
    axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT =
    axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic POL    = 1'(SYNC_POL);
  localparam pos_t V_ACTV = pos_t'(V_ACTIVE);

  logic   pix_ce;
  pos_t   h_q, h_d, v_q, v_d;
  logic   h_last, v_last;
  logic   h_win_d, v_win_d;
  logic   h_act_d, v_act_d;

  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   display_on_q, display_on_d;
  logic   vblank_start_q, vblank_start_d;
  frame_t frame_count_q, frame_count_d;

  assign pix_ce = vif.pix_ce;

  vga_axis_counter #(
    .TOTAL   (H_TOT),
    .ACTIVE  (H_ACTIVE),
    .SYNC_LO (H_ACTIVE + H_FP),
    .SYNC_HI (H_ACTIVE + H_FP + H_SYNC)
  ) u_h (
    .clk   (clk),
    .rst   (sys_rst),
    .adv   (pix_ce),
    .cnt_q (h_q),
    .cnt_d (h_d),
    .last  (h_last),
    .win_d (h_win_d),
    .act_d (h_act_d)
  );

  vga_axis_counter #(
    .TOTAL   (V_TOT),
    .ACTIVE  (V_ACTIVE),
    .SYNC_LO (V_ACTIVE + V_FP),
    .SYNC_HI (V_ACTIVE + V_FP + V_SYNC)
  ) u_v (
    .clk   (clk),
    .rst   (sys_rst),
    .adv   (pix_ce & h_last),
    .cnt_q (v_q),
    .cnt_d (v_d),
    .last  (v_last),
    .win_d (v_win_d),
    .act_d (v_act_d)
  );

  always_comb begin
    hsync_d        = h_win_d ? POL : ~POL;
    vsync_d        = v_win_d ? POL : ~POL;
    display_on_d   = h_act_d & v_act_d;
    vblank_start_d = pix_ce & (h_d == '0) &
                     (v_d == V_ACTV);
    frame_count_d  = frame_count_q;
    if (pix_ce && h_last && v_last) begin
      frame_count_d = frame_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      hsync_q        <= ~POL;
      vsync_q        <= ~POL;
      display_on_q   <= 1'b1;
      vblank_start_q <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
      display_on_q   <= display_on_d;
      vblank_start_q <= vblank_start_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign vif.hpos         = h_q;
  assign vif.vpos         = v_q;
  assign vif.hsync        = hsync_q;
  assign vif.vsync        = vsync_q;
  assign vif.display_on   = display_on_q;
  assign vif.vblank_start = vblank_start_q;
  assign vif.frame_count  = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: small-raster instance under random and directed
// pix_ce, plus a default-timing instance for 12 lines.
module tb_vga_timing_gen;

  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 2;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int SF  = SHT * SVT;

  localparam int DHA = 640, DHF = 16, DHS = 96, DHB = 48;
  localparam int DVA = 480, DVF = 10, DVS = 2,  DVB = 33;
  localparam int D_WIN = 12 * 800;

  typedef struct {
    longint h;
    longint v;
    longint hs;
    longint vs;
    longint de;
    longint fc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic s_rst = 1'b1;
  logic d_rst = 1'b1;
  logic s_ce  = 1'b0;
  logic d_ce  = 1'b1;

  int errs   = 0;
  int checks = 0;

  vga_timing_gen_if s_if ();
  vga_timing_gen_if d_if ();
  assign s_if.pix_ce = s_ce;
  assign d_if.pix_ce = d_ce;

  vga_timing_gen #(
    .H_ACTIVE (SHA), .H_FP (SHF),
    .H_SYNC   (SHS), .H_BP (SHB),
    .V_ACTIVE (SVA), .V_FP (SVF),
    .V_SYNC   (SVS), .V_BP (SVB),
    .SYNC_POL (0)
  ) u_s (
    .clk     (clk),
    .sys_rst (s_rst),
    .vif     (s_if.master)
  );

  vga_timing_gen u_d (
    .clk     (clk),
    .sys_rst (d_rst),
    .vif     (d_if.master)
  );

  task automatic chk(
    input string  tag,
    input longint got,
    input longint exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // Position from the number of pixel advances since reset.
  function automatic exp_t ref_pos(
    input longint t,
    input int ha, input int hf, input int hs, input int hb,
    input int va, input int vf, input int vs, input int vb
  );
    exp_t e;
    longint ht, vt;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    e.h  = t % ht;
    e.v  = (t / ht) % vt;
    e.fc = (t / (ht * vt)) % 256;
    e.hs = (e.h >= ha + hf && e.h < ha + hf + hs) ? 0 : 1;
    e.vs = (e.v >= va + vf && e.v < va + vf + vs) ? 0 : 1;
    e.de = (e.h < ha && e.v < va) ? 1 : 0;
    return e;
  endfunction

  longint s_t = 0;
  bit     s_adv = 0;
  longint d_t = 0;
  bit     d_adv = 0;

  always @(posedge clk or posedge s_rst) begin
    if (s_rst) begin
      s_t   <= 0;
      s_adv <= 0;
    end else begin
      s_adv <= s_ce;
      if (s_ce) s_t <= s_t + 1;
    end
  end

  always @(posedge clk or posedge d_rst) begin
    if (d_rst) begin
      d_t   <= 0;
      d_adv <= 0;
    end else begin
      d_adv <= d_ce;
      if (d_ce) d_t <= d_t + 1;
    end
  end

  bit s_on = 0;
  bit d_on = 0;

  always @(negedge clk) begin
    exp_t e;
    if (s_on) begin
      e = ref_pos(s_t, SHA, SHF, SHS, SHB,
                  SVA, SVF, SVS, SVB);
      chk("s_hpos",  s_if.hpos,        e.h);
      chk("s_vpos",  s_if.vpos,        e.v);
      chk("s_hsync", s_if.hsync,       e.hs);
      chk("s_vsync", s_if.vsync,       e.vs);
      chk("s_de",    s_if.display_on,  e.de);
      chk("s_fc",    s_if.frame_count, e.fc);
      chk("s_vbs",   s_if.vblank_start,
          (s_adv && e.h == 0 && e.v == SVA) ? 1 : 0);
    end
  end

  longint d_cyc = 0;
  longint d_fall = -1;
  logic   d_prev_hs = 1'b1;
  logic   d_prev_de = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    if (d_on && d_t <= D_WIN) begin
      e = ref_pos(d_t, DHA, DHF, DHS, DHB,
                  DVA, DVF, DVS, DVB);
      chk("d_hpos",  d_if.hpos,        e.h);
      chk("d_vpos",  d_if.vpos,        e.v);
      chk("d_hsync", d_if.hsync,       e.hs);
      chk("d_vsync", d_if.vsync,       e.vs);
      chk("d_de",    d_if.display_on,  e.de);
      chk("d_vbs",   d_if.vblank_start, 0);
      if (e.h == 640 && e.v == 10) begin
        chk("d_de_fall", d_if.display_on, 0);
        chk("d_de_prev", d_prev_de, 1);
      end
      if (d_prev_hs && !d_if.hsync) begin
        if (d_fall >= 0)
          chk("d_hs_period", d_cyc - d_fall, 800);
        d_fall = d_cyc;
      end
      d_prev_hs = d_if.hsync;
      d_prev_de = d_if.display_on;
      d_cyc++;
    end
  end

  initial begin
    @(posedge clk);
    #2;
    d_rst = 1'b0;
    d_on  = 1'b1;
  end

  task automatic cyc(input logic ce);
    s_ce = ce;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int     vbs_cnt;
    int     last_fall;
    logic   prev_hs;
    logic [9:0] prev_h;
    bit     hit;
    bit     wrapped;
    logic [7:0] prev_fc;

    @(posedge clk);
    #2;
    s_on = 1'b1;
    chk("rst_hpos",  s_if.hpos, 0);
    chk("rst_vpos",  s_if.vpos, 0);
    chk("rst_hsync", s_if.hsync, 1);
    chk("rst_vsync", s_if.vsync, 1);
    chk("rst_de",    s_if.display_on, 1);
    chk("rst_fc",    s_if.frame_count, 0);
    chk("rst_vbs",   s_if.vblank_start, 0);
    s_rst = 1'b0;

    // Continuous pix_ce: two full frames.
    vbs_cnt   = 0;
    last_fall = -1;
    prev_hs   = s_if.hsync;
    for (int n = 1; n <= 2 * SF; n++) begin
      cyc(1'b1);
      if (n <= SF && s_if.vblank_start) vbs_cnt++;
      if (prev_hs && !s_if.hsync) begin
        if (last_fall >= 0)
          chk("hs_period", n - last_fall, SHT);
        last_fall = n;
      end
      prev_hs = s_if.hsync;
      if (n == SF - 1) chk("fc_before", s_if.frame_count, 0);
      if (n == SF)     chk("fc_at",     s_if.frame_count, 1);
    end
    chk("vbs_once", vbs_cnt, 1);

    // Alternating pix_ce: half-rate frame.
    vbs_cnt = 0;
    for (int n = 1; n <= 2 * SF; n++) begin
      prev_h = s_if.hpos;
      cyc(n[0]);
      if (s_if.vblank_start) vbs_cnt++;
      if (!n[0]) chk("hold_h", s_if.hpos, prev_h);
      if (n == 2 * SF - 2)
        chk("tog_fc_before", s_if.frame_count, 2);
    end
    chk("tog_fc_at", s_if.frame_count, 3);
    chk("tog_vbs_once", vbs_cnt, 1);

    // Random pix_ce.
    for (int n = 0; n < 2000; n++)
      cyc(1'($urandom_range(0, 1)));

    // Reset inside both sync windows.
    hit = 1'b0;
    for (int n = 0; n < 2 * SF && !hit; n++) begin
      if (s_if.hpos == 11 && s_if.vpos == 8) hit = 1'b1;
      else cyc(1'b1);
    end
    chk("rst_wait_pos", hit, 1);
    chk("pre_rst_hs", s_if.hsync, 0);
    chk("pre_rst_vs", s_if.vsync, 0);
    s_rst = 1'b1;
    #1;
    chk("mid_rst_hpos", s_if.hpos, 0);
    chk("mid_rst_vpos", s_if.vpos, 0);
    chk("mid_rst_hs",   s_if.hsync, 1);
    chk("mid_rst_vs",   s_if.vsync, 1);
    chk("mid_rst_de",   s_if.display_on, 1);
    chk("mid_rst_fc",   s_if.frame_count, 0);
    cyc(1'b1);
    #1;
    s_rst = 1'b0;
    cyc(1'b1);
    chk("post_rst_hpos", s_if.hpos, 1);
    chk("post_rst_vpos", s_if.vpos, 0);

    // 256 frames: frame_count wraps.
    wrapped = 1'b0;
    prev_fc = s_if.frame_count;
    for (int n = 0; n < 256 * SF; n++) begin
      cyc(1'b1);
      if (prev_fc == 8'd255 && s_if.frame_count == 8'd0)
        wrapped = 1'b1;
      prev_fc = s_if.frame_count;
    end
    chk("fc_wrap_seen", wrapped, 1);
    chk("fc_wrap_end",  s_if.frame_count, 0);
    chk("wrap_hpos",    s_if.hpos, 1);

    s_on = 1'b0;
    d_on = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL take parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 The block SHALL take parameter H_FP, default 16: horizontal front porch in pixels.
REQ-003 The block SHALL take parameter H_SYNC, default 96: horizontal sync width in pixels.
REQ-004 The block SHALL take parameter H_BP, default 48: horizontal back porch in pixels.
REQ-005 The block SHALL take parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 The block SHALL take parameter V_FP, default 10: vertical front porch in lines.
REQ-007 The block SHALL take parameter V_SYNC, default 2: vertical sync width in lines.
REQ-008 The block SHALL take parameter V_BP, default 33: vertical back porch in lines.
REQ-009 The block SHALL take parameter SYNC_POL, default 0: asserted level of hsync/vsync (0 = active-low).
REQ-010 clk  input  1  single clock for all logic.
REQ-011 sys_rst  input  1  asynchronous reset, active-high.
REQ-012 pix_ce  input  1  pixel-advance enable, sampled each clk.
REQ-013 hpos  output  10  current pixel column, 0..H_TOTAL-1.
REQ-014 vpos  output  10  current line, 0..V_TOTAL-1.
REQ-015 hsync  output  1  horizontal sync, level per SYNC_POL.
REQ-016 vsync  output  1  vertical sync, level per SYNC_POL.
REQ-017 display_on  output  1  high when (hpos,vpos) is inside the visible area.
REQ-018 vblank_start  output  1  one-clk strobe marking the first cycle of vertical blanking.
REQ-019 frame_count  output  8  count of completed frames.

Function
REQ-020 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (default 800), and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
REQ-021 On each clk edge with pix_ce=1, hpos SHALL increment; if hpos=H_TOTAL-1, it SHALL wrap to 0 and vpos SHALL increment instead.
REQ-022 If vpos=V_TOTAL-1 when hpos wraps, vpos SHALL wrap to 0 and frame_count SHALL increment, modulo 256.
REQ-023 On each clk edge with pix_ce=0, all counters and registered outputs SHALL hold, and vblank_start SHALL be 0.
REQ-024 hsync, vsync and display_on SHALL be registered, computed from the next counter values, so they align exactly with the hpos/vpos shown in the same cycle (zero relative latency, no combinational glitches).
REQ-025 hsync SHALL be asserted iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC (default 656..751).
REQ-026 vsync SHALL be asserted iff V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC (default 490..491), independent of hpos.
REQ-027 display_on SHALL be 1 iff hpos<H_ACTIVE and vpos<V_ACTIVE.
REQ-028 vblank_start SHALL be high for exactly one clk, in the first cycle in which (hpos,vpos)=(0,V_ACTIVE), regardless of pix_ce in that cycle.
REQ-029 Counter arithmetic SHALL be unsigned 10-bit, and the counters SHALL never reach values >= H_TOTAL or >= V_TOTAL.
REQ-030 pix_ce held continuously high SHALL produce a frame every H_TOTAL*V_TOTAL clks (420000 at default).

Reset
REQ-031 Asserting sys_rst SHALL immediately set hpos=0, vpos=0, frame_count=0, vblank_start=0, display_on=1 and hsync=vsync=~SYNC_POL.
REQ-032 Asserting sys_rst mid-frame or mid-sync SHALL abandon the frame without completing it, and the first pix_ce after release SHALL advance to (1,0).

Structure
REQ-033 The default timing constants, H_TOTAL and V_TOTAL SHALL live in the shared package vga_timing_pkg, for reuse by the renderer.
REQ-034 A parameterised sub-module vga_axis_counter (count, wrap flag, sync-window decode) SHALL be instantiated once per axis.

Verification
REQ-035 Bench: pix_ce=1 continuously from reset -> hsync low for hpos 656..751, with the hsync period equal to 800 clks.
REQ-036 Bench: run one full frame -> vsync low only for vpos 490..491 (1600 clks), vblank_start seen exactly once at (0,480), and frame_count going 0->1 at the 420000th clk.
REQ-037 Bench: pix_ce toggling 1/0 -> all outputs hold on the 0 cycles, the frame takes 840000 clks, and vblank_start is still one clk wide.
REQ-038 Bench: assert sys_rst at (700,491) -> the next sampled outputs are (0,0), hsync=vsync=1, display_on=1 and frame_count=0.
REQ-039 Bench: force 256 frames -> frame_count wraps 255->0 without disturbing the sync outputs.
REQ-040 Bench: at hpos=639->640 with vpos=10 -> display_on falls in the same cycle that hpos shows 640.
